// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the instruction fetch front end.
//   branch_resolved_t : branch redirect from the back end (taken, target)
//   except_req_t      : exception redirect (valid, target)
//   mmu_resp_t        : translation status of the fetch address (also used as
//                       the per-entry fetch exception record)
//   pipe_if_t         : one decode lane (valid, vaddr, inst, iaddr_ex)
package inst_fetch_queue_pkg;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } branch_resolved_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } except_req_t;

  typedef struct packed {
    logic illegal;
    logic miss;
    logic inv;
  } mmu_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] vaddr;
    logic [31:0] inst;
    mmu_resp_t   iaddr_ex;
  } pipe_if_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: PC generation, a single-outstanding icache
// request FSM and a circular instruction queue feeding N_ISSUE decode lanes.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   resolved_branch   branch redirect (taken, target)
//   except_req        exception redirect (valid, target); wins over branch
//   npc               fetch address, aligned to FETCH_WIDTH*4 bytes
//   ibus_req          icache request valid
//   ibus_ready        icache accepts the request this cycle
//   mmu_iaddr_resp    translation status of npc, same cycle
//   ibus_valid        icache response valid
//   ibus_rddata       FETCH_WIDTH response words, word 0 in [31:0]
//   ready_i           decode consumes every valid lane this cycle
//   pipe_if           decode lanes, lane i = queue head + i
//   pipe_if_flush     redirect in progress this cycle
//   queue_count       occupied queue entries
//   fsm_state         debug view of the request FSM (0 idle, 1 wait, 2 drop)
//
// Handshakes: a request transfers on a clock edge where ibus_req && ibus_ready;
// ibus_req never depends on ibus_ready. The response is a single-cycle
// ibus_valid pulse with no back-pressure. Decode lanes transfer on an edge
// where ready_i is high, and then every valid lane is consumed at once.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter logic [31:0] BOOT_VEC    = 32'hbfc00000,
  parameter int          FETCH_WIDTH = 2,
  parameter int          N_ISSUE     = 2,
  parameter int          QUEUE_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  branch_resolved_t                   resolved_branch,
  input  except_req_t                        except_req,
  output logic [31:0]                        npc,
  output logic                               ibus_req,
  input  logic                               ibus_ready,
  input  mmu_resp_t                          mmu_iaddr_resp,
  input  logic                               ibus_valid,
  input  logic [32*FETCH_WIDTH-1:0]          ibus_rddata,
  input  logic                               ready_i,
  output pipe_if_t                           pipe_if [N_ISSUE],
  output logic                               pipe_if_flush,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output logic [1:0]                         fsm_state
);

  localparam int LG = $clog2(FETCH_WIDTH*4);
  localparam int OW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [31:0]     pc;
  logic            halt;
  logic [OW-1:0]   offset;
  logic [31:0]     addr_latched;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;

  logic [31:0]     mem_vaddr [QUEUE_DEPTH];
  logic [31:0]     mem_inst  [QUEUE_DEPTH];
  mmu_resp_t       mem_ex    [QUEUE_DEPTH];

  logic            flush;
  logic [31:0]     redirect_pc;
  logic [CW-1:0]   free;
  logic            issue_ok;
  logic            mmu_fault;
  logic            fault_push;
  logic            resp_push;
  logic            accept;
  logic [CW-1:0]   push_n, pop_n;

  assign flush         = except_req.valid | resolved_branch.taken;
  assign redirect_pc   = except_req.valid ? except_req.target : resolved_branch.target;
  assign pipe_if_flush = flush;
  assign npc           = {pc[31:LG], {LG{1'b0}}};
  assign queue_count   = count;
  assign fsm_state     = state;
  assign free          = CW'(QUEUE_DEPTH) - count;
  assign mmu_fault     = |mmu_iaddr_resp;

  // Credit check: only fetch when a whole response is guaranteed to fit,
  // so the response (or the single fault entry) never overflows the queue.
  assign issue_ok   = (state == S_IDLE) && !halt && !flush &&
                      (free >= CW'(FETCH_WIDTH));
  // The request is held low while reset is asserted.
  assign ibus_req   = rst_n && issue_ok && !mmu_fault;
  assign fault_push = issue_ok && mmu_fault;
  assign resp_push  = (state == S_WAIT) && ibus_valid && !flush;
  assign accept     = ibus_req && ibus_ready;

  always_comb begin
    push_n = '0;
    pop_n  = '0;
    if (fault_push)
      push_n = CW'(1);
    else if (resp_push)
      push_n = CW'(FETCH_WIDTH) - CW'(offset);
    if (ready_i && !flush)
      pop_n = (count >= CW'(N_ISSUE)) ? CW'(N_ISSUE) : count;
  end

  // Next state. A flush while waiting turns the outstanding request into one
  // whose response must be thrown away, unless it arrives in the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_WAIT;
      S_WAIT: begin
        if (ibus_valid)  state_nx = S_IDLE;
        else if (flush)  state_nx = S_DROP;
      end
      S_DROP: if (ibus_valid) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= BOOT_VEC;
      halt         <= 1'b0;
      offset       <= '0;
      addr_latched <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        pc    <= redirect_pc;
        halt  <= 1'b0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (fault_push)
          halt <= 1'b1;
        if (accept) begin
          // Word offset of a mid-block target: leading words are skipped.
          offset       <= OW'((pc >> 2) & 32'(FETCH_WIDTH-1));
          addr_latched <= npc;
          pc           <= npc + 32'(FETCH_WIDTH*4);
        end
        head  <= head + PW'(pop_n);
        tail  <= tail + PW'(push_n);
        count <= count + push_n - pop_n;
      end
    end
  end

  // Queue storage needs no reset: entries are only visible below count.
  always_ff @(posedge clk) begin
    if (fault_push) begin
      mem_vaddr[tail] <= pc;
      mem_inst[tail]  <= '0;
      mem_ex[tail]    <= mmu_iaddr_resp;
    end else if (resp_push) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (k >= int'(offset)) begin
          mem_vaddr[tail + PW'(k) - PW'(offset)] <= addr_latched + 32'(4*k);
          mem_inst[tail + PW'(k) - PW'(offset)]  <= ibus_rddata[32*k +: 32];
          mem_ex[tail + PW'(k) - PW'(offset)]    <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_ISSUE; i++) begin
      pipe_if[i].valid    = (count > CW'(i)) && !flush;
      pipe_if[i].vaddr    = mem_vaddr[head + PW'(i)];
      pipe_if[i].inst     = mem_inst[head + PW'(i)];
      pipe_if[i].iaddr_ex = mem_ex[head + PW'(i)];
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int          FW   = 2;
  localparam int          NI   = 2;
  localparam int          QD   = 8;
  localparam logic [31:0] BOOT = 32'hbfc00000;
  localparam int          EW   = 67;  // {iaddr_ex[2:0], vaddr, inst}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolved_t resolved_branch;
  except_req_t      except_req;
  logic [31:0]      npc;
  logic             ibus_req;
  logic             ibus_ready;
  mmu_resp_t        mmu_iaddr_resp;
  logic             ibus_valid;
  logic [32*FW-1:0] ibus_rddata;
  logic             ready_i;
  pipe_if_t         pipe_if [NI];
  logic             pipe_if_flush;
  logic [3:0]       queue_count;
  logic [1:0]       fsm_state;

  inst_fetch_queue #(
    .BOOT_VEC(BOOT), .FETCH_WIDTH(FW), .N_ISSUE(NI), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .resolved_branch(resolved_branch), .except_req(except_req),
    .npc(npc), .ibus_req(ibus_req), .ibus_ready(ibus_ready),
    .mmu_iaddr_resp(mmu_iaddr_resp), .ibus_valid(ibus_valid),
    .ibus_rddata(ibus_rddata), .ready_i(ready_i),
    .pipe_if(pipe_if), .pipe_if_flush(pipe_if_flush),
    .queue_count(queue_count), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc;
  logic        m_halt, m_out, m_drop;
  int          m_off, lat;
  logic [31:0] m_addr;

  // stimulus knobs
  int          p_ready, p_ibr, lat_max, p_br, p_exc, p_mmu;
  logic        br_force, exc_force, fault_addr_en, late_valid;
  logic [31:0] br_tgt, exc_tgt, fault_addr;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver + per-cycle model ----------------
  task automatic step();
    logic        flush, can_issue, fault, exp_v;
    logic [31:0] al;
    logic [EW-1:0] e;
    int          size, pops;
    @(negedge clk);
    al = {m_pc[31:3], 3'b000};
    ready_i    = ($urandom_range(99) < p_ready);
    ibus_ready = ($urandom_range(99) < p_ibr);
    resolved_branch.taken  = br_force || ($urandom_range(999) < p_br);
    resolved_branch.target = br_force ? br_tgt : ($urandom() & 32'hffff_fffc);
    except_req.valid  = exc_force || ($urandom_range(999) < p_exc);
    except_req.target = exc_force ? exc_tgt : ($urandom() & 32'hffff_fffc);
    mmu_iaddr_resp = mmu_resp_t'(3'b000);
    if (fault_addr_en && al == fault_addr)
      mmu_iaddr_resp = mmu_resp_t'(3'b010);
    else if ($urandom_range(999) < p_mmu)
      mmu_iaddr_resp = mmu_resp_t'(3'(1 << $urandom_range(2)));
    ibus_valid  = 1'b0;
    ibus_rddata = {$urandom(), $urandom()};
    if (late_valid) begin
      ibus_valid = 1'b1;
      late_valid = 1'b0;
    end else if (m_out) begin
      if (lat == 0) ibus_valid = 1'b1;
      else lat--;
    end
    #1;
    flush     = except_req.valid | resolved_branch.taken;
    size      = exp_q.size();
    can_issue = !m_out && !m_halt && !flush && (QD - size >= FW);
    fault     = |mmu_iaddr_resp;
    check_eq("ibus_req", 32'(ibus_req), 32'(can_issue && !fault));
    check_eq("npc", npc, al);
    check_eq("flush", 32'(pipe_if_flush), 32'(flush));
    check_eq("count", 32'(queue_count), 32'(size));
    for (int i = 0; i < NI; i++) begin
      exp_v = (size > i) && !flush;
      check_eq("lane_valid", 32'(pipe_if[i].valid), 32'(exp_v));
      if (exp_v) begin
        e = exp_q[i];
        check_eq("lane_vaddr", pipe_if[i].vaddr, e[63:32]);
        check_eq("lane_inst", pipe_if[i].inst, e[31:0]);
        check_eq("lane_ex", 32'(pipe_if[i].iaddr_ex), 32'(e[66:64]));
      end
    end
    // model update for the coming clock edge
    if (flush) begin
      if (ibus_valid) begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else if (m_out) begin
        m_drop = 1'b1;
      end
      exp_q.delete();
      m_halt = 1'b0;
      m_pc   = except_req.valid ? except_req.target : resolved_branch.target;
    end else begin
      if (ready_i) begin
        pops = (size < NI) ? size : NI;
        repeat (pops) void'(exp_q.pop_front());
      end
      if (m_out && ibus_valid) begin
        if (!m_drop)
          for (int k = m_off; k < FW; k++)
            exp_q.push_back({3'b000, m_addr + 32'(4*k), ibus_rddata[32*k +: 32]});
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else if (can_issue) begin
        if (fault) begin
          exp_q.push_back({mmu_iaddr_resp, m_pc, 32'h0});
          m_halt = 1'b1;
        end else if (ibus_ready) begin
          m_out  = 1'b1;
          m_off  = int'((m_pc >> 2) & 32'(FW-1));
          m_addr = al;
          m_pc   = al + 32'(FW*4);
          lat    = $urandom_range(lat_max);
        end
      end
    end
  endtask

  task automatic quiet_knobs();
    p_br = 0; p_exc = 0; p_mmu = 0;
    br_force = 1'b0; exc_force = 1'b0; fault_addr_en = 1'b0; late_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ready_i = 1'b0; ibus_ready = 1'b0; ibus_valid = 1'b0; ibus_rddata = '0;
    mmu_iaddr_resp = mmu_resp_t'(3'b000);
    except_req = '0;
    resolved_branch = '0;
    resolved_branch.taken = 1'b1;
    #1;
    check_eq("rst_flush_follows", 32'(pipe_if_flush), 32'd1);
    resolved_branch.taken = 1'b0;
    #1;
    check_eq("rst_flush_low", 32'(pipe_if_flush), 32'd0);
    check_eq("rst_ibus_req", 32'(ibus_req), 32'd0);
    check_eq("rst_count", 32'(queue_count), 32'd0);
    check_eq("rst_fsm", 32'(fsm_state), 32'd0);
    for (int i = 0; i < NI; i++)
      check_eq("rst_lane_valid", 32'(pipe_if[i].valid), 32'd0);
    m_pc = BOOT; m_halt = 1'b0; m_out = 1'b0; m_drop = 1'b0;
    m_off = 0; m_addr = '0; lat = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    quiet_knobs();
    p_ready = 0; p_ibr = 100; lat_max = 0;
    br_tgt = '0; exc_tgt = '0; fault_addr = '0;
    except_req = '0; resolved_branch = '0;
    ready_i = 1'b0; ibus_ready = 1'b0; ibus_valid = 1'b0; ibus_rddata = '0;
    mmu_iaddr_resp = mmu_resp_t'(3'b000);
    do_reset();

    // boot fetch, 1-cycle response
    step();
    check_eq("t1_npc0", npc, 32'hbfc00000);
    check_eq("t1_req0", 32'(ibus_req), 32'd1);
    step();
    check_eq("t1_npc1", npc, 32'hbfc00008);
    step();
    check_eq("t1_l0_vaddr", pipe_if[0].vaddr, 32'hbfc00000);
    check_eq("t1_l1_vaddr", pipe_if[1].vaddr, 32'hbfc00004);

    // branch into the middle of a fetch block
    br_force = 1'b1; br_tgt = 32'h80000004;
    step();
    br_force = 1'b0;
    step();
    check_eq("t2_npc", npc, 32'h80000000);
    step();
    step();
    check_eq("t2_count", 32'(queue_count), 32'd1);
    check_eq("t2_l0_vaddr", pipe_if[0].vaddr, 32'h80000004);
    check_eq("t2_npc_next", npc, 32'h80000008);

    // exception + branch together while a request is outstanding
    p_ready = 100; lat_max = 3;
    n = 0;
    while (!(m_out && lat > 0) && n < 30) begin step(); n++; end
    check_eq("t3_wait_reached", 32'(m_out && lat > 0), 32'd1);
    exc_force = 1'b1; exc_tgt = 32'hbfc00380;
    br_force  = 1'b1; br_tgt  = 32'h12345678;
    step();
    exc_force = 1'b0; br_force = 1'b0;
    step();
    check_eq("t3_fsm_drop", 32'(fsm_state), 32'd2);
    n = 0;
    while (!ibus_req && n < 20) begin step(); n++; end
    check_eq("t3_npc", npc, 32'hbfc00380);
    check_eq("t3_count", 32'(queue_count), 32'd0);

    // fill the queue with decode stalled
    p_ready = 0; lat_max = 0;
    n = 0;
    while (queue_count != 4'd8 && n < 40) begin step(); n++; end
    check_eq("t4_full", 32'(queue_count), 32'd8);
    repeat (3) begin
      step();
      check_eq("t4_req_held", 32'(ibus_req), 32'd0);
    end
    p_ready = 100;
    step();
    p_ready = 0;
    step();
    check_eq("t4_count_after_pop", 32'(queue_count), 32'd6);
    check_eq("t4_req_again", 32'(ibus_req), 32'd1);

    // mmu miss halts fetch until the next redirect
    br_force = 1'b1; br_tgt = 32'h00400000;
    fault_addr_en = 1'b1; fault_addr = 32'h00400000;
    step();
    br_force = 1'b0;
    step();
    check_eq("t5_no_req", 32'(ibus_req), 32'd0);
    step();
    check_eq("t5_count", 32'(queue_count), 32'd1);
    check_eq("t5_vaddr", pipe_if[0].vaddr, 32'h00400000);
    check_eq("t5_inst", pipe_if[0].inst, 32'h0);
    check_eq("t5_miss", 32'(pipe_if[0].iaddr_ex.miss), 32'd1);
    repeat (3) begin
      step();
      check_eq("t5_halt", 32'(ibus_req), 32'd0);
    end
    fault_addr_en = 1'b0;
    br_force = 1'b1; br_tgt = 32'hfffffffc;
    step();
    br_force = 1'b0;
    // address wrap: fetch of the last block then 0x00000000
    p_ready = 100;
    step();
    check_eq("t6_npc_top", npc, 32'hfffffff8);
    step();
    step();
    check_eq("t6_npc_wrap", npc, 32'h00000000);

    // reset in the middle of a request, then a late response in idle
    p_ready = 50; lat_max = 3;
    n = 0;
    while (!m_out && n < 30) begin step(); n++; end
    check_eq("t7_outstanding", 32'(m_out), 32'd1);
    do_reset();
    late_valid = 1'b1;
    repeat (6) step();

    // randomized traffic
    p_ready = 60; p_ibr = 70; lat_max = 3; p_br = 20; p_exc = 10; p_mmu = 5;
    repeat (3000) step();
    quiet_knobs();
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
